// File: rtl/mem_access_seq_if.sv
// Core request bus and data-RAM port bundle for mem_access_seq.
// Core requests must be stable while they wait: it raises Req and holds it and its fields until a one-cycle Done; fields are sampled only in IDLE.
interface mem_access_seq_if;
    logic        Req;
    logic [1:0]  WriteType;
    logic [1:0]  ReadType;
    logic        SignExt;
    logic [31:0] Addr;
    logic [31:0] WData;
    logic [31:0] RData;
    logic        Done;
    logic        Busy;
    logic        Misalign;
    logic [29:0] MemAddr;
    logic        MemRE;
    logic        MemWE;
    logic [31:0] MemWData;
    logic [31:0] MemRData;

    modport slave (
        input  Req, WriteType, ReadType, SignExt, Addr, WData, MemRData,
        output RData, Done, Busy, Misalign, MemAddr, MemRE, MemWE, MemWData
    );

    modport master (
        output Req, WriteType, ReadType, SignExt, Addr, WData, MemRData,
        input  RData, Done, Busy, Misalign, MemAddr, MemRE, MemWE, MemWData
    );
endinterface

// File: rtl/mem_access_seq.sv
// Byte/half/word load-store sequencer over a word-wide synchronous data RAM.
// Optional MEM_MISALIGN_TRAP_EN: misaligned half/word accesses complete at once with Misalign set.
module mem_access_seq (
    input  logic              CLK,
    input  logic              RESETn,
    mem_access_seq_if.slave   bus,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WAIT = 3'd2,
        S_WR   = 3'd3,
        S_DONE = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [1:0]  wtype_q, wtype_d;
    logic [1:0]  rtype_q, rtype_d;
    logic        sext_q, sext_d;
    logic        misalign_q, misalign_d;

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_word;
    logic [31:0] merged_word;
    logic        acc_misaligned;

`ifdef MEM_MISALIGN_TRAP_EN
    logic [1:0]  acc_type;
    // A store's size decides alignment whenever both sizes are given.
    assign acc_type       = (bus.WriteType != 2'b00) ? bus.WriteType : bus.ReadType;
    assign acc_misaligned = ((acc_type == 2'b10) && bus.Addr[0]) ||
                            ((acc_type == 2'b11) && (bus.Addr[1:0] != 2'b00));
`else
    assign acc_misaligned = 1'b0;
`endif

    always_comb begin
        sel_byte = bus.MemRData[7:0];
        case (addr_q[1:0])
            2'd1:    sel_byte = bus.MemRData[15:8];
            2'd2:    sel_byte = bus.MemRData[23:16];
            2'd3:    sel_byte = bus.MemRData[31:24];
            default: sel_byte = bus.MemRData[7:0];
        endcase
        sel_half = addr_q[1] ? bus.MemRData[31:16] : bus.MemRData[15:0];

        load_word = bus.MemRData;
        case (rtype_q)
            2'b01:   load_word = {{24{sext_q & sel_byte[7]}}, sel_byte};
            2'b10:   load_word = {{16{sext_q & sel_half[15]}}, sel_half};
            default: load_word = bus.MemRData;
        endcase

        // Read-modify-write: only the addressed lane is replaced.
        merged_word = bus.MemRData;
        case (wtype_q)
            2'b01: begin
                case (addr_q[1:0])
                    2'd0:    merged_word[7:0]   = wdata_q[7:0];
                    2'd1:    merged_word[15:8]  = wdata_q[7:0];
                    2'd2:    merged_word[23:16] = wdata_q[7:0];
                    default: merged_word[31:24] = wdata_q[7:0];
                endcase
            end
            2'b10: begin
                if (addr_q[1]) merged_word[31:16] = wdata_q[15:0];
                else           merged_word[15:0]  = wdata_q[15:0];
            end
            default: merged_word = wdata_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        mem_wdata_d = mem_wdata_q;
        wtype_d     = wtype_q;
        rtype_d     = rtype_q;
        sext_d      = sext_q;
        misalign_d  = misalign_q;
        case (state_q)
            S_IDLE: begin
                misalign_d = 1'b0;
                if (bus.Req) begin
                    addr_d  = bus.Addr;
                    wdata_d = bus.WData;
                    wtype_d = bus.WriteType;
                    rtype_d = bus.ReadType;
                    sext_d  = bus.SignExt;
                    if (acc_misaligned) begin
                        misalign_d = 1'b1;
                        state_d    = S_DONE;
                    end else if (bus.WriteType == 2'b11) begin
                        mem_wdata_d = bus.WData;
                        state_d     = S_WR;
                    end else if ((bus.WriteType != 2'b00) || (bus.ReadType != 2'b00)) begin
                        state_d = S_RD;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_RD:   state_d = S_WAIT;
            S_WAIT: begin
                if (wtype_q != 2'b00) begin
                    mem_wdata_d = merged_word;
                    state_d     = S_WR;
                end else begin
                    rdata_d = load_word;
                    state_d = S_DONE;
                end
            end
            S_WR:   state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q     <= S_IDLE;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            rdata_q     <= 32'h0;
            mem_wdata_q <= 32'h0;
            wtype_q     <= 2'b00;
            rtype_q     <= 2'b00;
            sext_q      <= 1'b0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            mem_wdata_q <= mem_wdata_d;
            wtype_q     <= wtype_d;
            rtype_q     <= rtype_d;
            sext_q      <= sext_d;
            misalign_q  <= misalign_d;
        end
    end

    assign bus.RData    = rdata_q;
    assign bus.Done     = (state_q == S_DONE);
    assign bus.Busy     = (state_q != S_IDLE);
    assign bus.Misalign = misalign_q & (state_q == S_DONE);
    assign bus.MemAddr  = addr_q[31:2];
    assign bus.MemRE    = (state_q == S_RD);
    assign bus.MemWE    = (state_q == S_WR);
    assign bus.MemWData = mem_wdata_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_mem_access_seq.sv
// Self-checking bench for mem_access_seq: vector table plus reset-abort and back-to-back sequences.
module tb_mem_access_seq;

  typedef struct {
    logic [1:0]  wt;
    logic [1:0]  rt;
    logic        sx;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        pl;
    logic [31:0] pl_word;
    logic        is_load;
    logic [31:0] exp_rdata;
    logic [31:0] exp_mwd;
    int          lat;
    int          n_re;
    int          n_we;
    logic        mis;
  } vec_t;

  logic        CLK = 1'b0;
  logic        RESETn;
  logic [2:0]  dbg_state;
  mem_access_seq_if bus();

  mem_access_seq dut (
    .CLK       (CLK),
    .RESETn    (RESETn),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  always #5 CLK = ~CLK;

  // data RAM model with a preload port
  logic [31:0] ram [0:63];
  logic        pl_en;
  logic [5:0]  pl_idx;
  logic [31:0] pl_data;

  always @(posedge CLK) begin
    if (pl_en) ram[pl_idx] <= pl_data;
    else if (bus.MemWE) ram[bus.MemAddr[5:0]] <= bus.MemWData;
    if (bus.MemRE) bus.MemRData <= ram[bus.MemAddr[5:0]];
  end

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_wr_q[$];
  logic [31:0] last_rd;
  vec_t vt[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pop_check_rdata(input string name);
    if (exp_q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: Done with no expected entry, RData %h", name, bus.RData);
    end else begin
      check(name, bus.RData, exp_q.pop_front());
    end
  endtask

  task automatic pop_check_wdata(input string name);
    if (exp_wr_q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: unexpected MemWE, MemWData %h expected none", name, bus.MemWData);
    end else begin
      check(name, bus.MemWData, exp_wr_q.pop_front());
    end
  endtask

  task automatic preload(input logic [5:0] idx, input logic [31:0] data);
    pl_en = 1'b1; pl_idx = idx; pl_data = data;
    @(negedge CLK);
    pl_en = 1'b0;
  endtask

  function automatic vec_t mk(input logic [1:0] wt, input logic [1:0] rt, input logic sx,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic pl, input logic [31:0] pl_word,
                              input logic is_load, input logic [31:0] exp_rdata,
                              input logic [31:0] exp_mwd, input int lat, input int n_re,
                              input int n_we, input logic mis);
    vec_t v;
    v.wt = wt; v.rt = rt; v.sx = sx; v.addr = addr; v.wdata = wdata;
    v.pl = pl; v.pl_word = pl_word; v.is_load = is_load; v.exp_rdata = exp_rdata;
    v.exp_mwd = exp_mwd; v.lat = lat; v.n_re = n_re; v.n_we = n_we; v.mis = mis;
    return v;
  endfunction

  // Starts and ends at a falling edge with the sequencer idle.
  task automatic do_access(input vec_t v);
    int re_n, we_n, done_cyc;
    logic [31:0] e;
    if (v.pl) preload(v.addr[7:2], v.pl_word);
    bus.Req = 1'b1; bus.WriteType = v.wt; bus.ReadType = v.rt;
    bus.SignExt = v.sx; bus.Addr = v.addr; bus.WData = v.wdata;
    e = v.is_load ? v.exp_rdata : last_rd;
    exp_q.push_back(e);
    last_rd = e;
    if (v.n_we != 0) exp_wr_q.push_back(v.exp_mwd);
    re_n = 0; we_n = 0; done_cyc = 0;
    for (int c = 1; c <= 12 && done_cyc == 0; c++) begin
      @(negedge CLK);
      check("re_we_exclusive", {31'b0, bus.MemRE & bus.MemWE}, 32'h0);
      if (bus.MemRE) begin
        re_n++;
        check("re_addr", {2'b0, bus.MemAddr}, {2'b0, v.addr[31:2]});
      end
      if (bus.MemWE) begin
        we_n++;
        check("we_addr", {2'b0, bus.MemAddr}, {2'b0, v.addr[31:2]});
        pop_check_wdata("mem_wdata");
      end
      if (bus.Done) begin
        done_cyc = c;
        pop_check_rdata("rdata");
        check("misalign", {31'b0, bus.Misalign}, {31'b0, v.mis});
        check("busy_in_done", {31'b0, bus.Busy}, 32'h1);
      end
    end
    bus.Req = 1'b0;
    if (done_cyc == 0) begin
      $display("FAIL done_timeout: no Done within 12 cycles, addr %h", v.addr);
      exp_q.delete();
      exp_wr_q.delete();
    end
    check("latency", done_cyc, v.lat);
    check("re_pulses", re_n, v.n_re);
    check("we_pulses", we_n, v.n_we);
    @(negedge CLK);
    check("idle_busy", {31'b0, bus.Busy}, 32'h0);
    check("done_one_cycle", {31'b0, bus.Done}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_we_seen, n_done_seen, d1, d2, busy_low, dn;
    RESETn = 1'b0;
    bus.Req = 1'b0; bus.WriteType = 2'b00; bus.ReadType = 2'b00;
    bus.SignExt = 1'b0; bus.Addr = 32'h0; bus.WData = 32'h0;
    pl_en = 1'b0; pl_idx = 6'h0; pl_data = 32'h0;
    last_rd = 32'h0;

    #12;
    check("rst_rdata", bus.RData, 32'h0);
    check("rst_done", {31'b0, bus.Done}, 32'h0);
    check("rst_busy", {31'b0, bus.Busy}, 32'h0);
    check("rst_misalign", {31'b0, bus.Misalign}, 32'h0);
    check("rst_memaddr", {2'b0, bus.MemAddr}, 32'h0);
    check("rst_memre", {31'b0, bus.MemRE}, 32'h0);
    check("rst_memwe", {31'b0, bus.MemWE}, 32'h0);
    check("rst_memwdata", bus.MemWData, 32'h0);
    @(negedge CLK);
    RESETn = 1'b1;
    @(negedge CLK);

    //        wt rt sx addr    wdata         pl  pl_word       ld  exp_rdata     exp_mwd     lat re we mis
    vt.push_back(mk(3, 0, 0, 32'h10, 32'hDEADBEEF, 0, 32'h0,        0, 32'h0,        32'hDEADBEEF, 2, 0, 1, 0));
    vt.push_back(mk(1, 0, 0, 32'h22, 32'h123456AA, 1, 32'h11223344, 0, 32'h0,        32'h11AA3344, 4, 1, 1, 0));
    vt.push_back(mk(0, 1, 1, 32'h32, 32'h0,        1, 32'h80FF7F01, 1, 32'hFFFFFFFF, 32'h0,        3, 1, 0, 0));
    vt.push_back(mk(0, 2, 0, 32'h32, 32'h0,        0, 32'h0,        1, 32'h000080FF, 32'h0,        3, 1, 0, 0));
    vt.push_back(mk(0, 1, 1, 32'h30, 32'h0,        0, 32'h0,        1, 32'h00000001, 32'h0,        3, 1, 0, 0));
    vt.push_back(mk(0, 1, 1, 32'h31, 32'h0,        0, 32'h0,        1, 32'h0000007F, 32'h0,        3, 1, 0, 0));
    vt.push_back(mk(0, 2, 1, 32'h30, 32'h0,        0, 32'h0,        1, 32'h00007F01, 32'h0,        3, 1, 0, 0));
    vt.push_back(mk(0, 2, 1, 32'h32, 32'h0,        0, 32'h0,        1, 32'hFFFF80FF, 32'h0,        3, 1, 0, 0));
    vt.push_back(mk(0, 1, 0, 32'h33, 32'h0,        0, 32'h0,        1, 32'h00000080, 32'h0,        3, 1, 0, 0));
    vt.push_back(mk(0, 1, 1, 32'h33, 32'h0,        0, 32'h0,        1, 32'hFFFFFF80, 32'h0,        3, 1, 0, 0));
    vt.push_back(mk(0, 3, 1, 32'h30, 32'h0,        0, 32'h0,        1, 32'h80FF7F01, 32'h0,        3, 1, 0, 0));
    vt.push_back(mk(2, 0, 0, 32'h30, 32'hFFFFBEEF, 0, 32'h0,        0, 32'h0,        32'h80FFBEEF, 4, 1, 1, 0));
    vt.push_back(mk(0, 3, 0, 32'h30, 32'h0,        0, 32'h0,        1, 32'h80FFBEEF, 32'h0,        3, 1, 0, 0));
    vt.push_back(mk(2, 0, 0, 32'h32, 32'hAAAA1234, 0, 32'h0,        0, 32'h0,        32'h1234BEEF, 4, 1, 1, 0));
    vt.push_back(mk(1, 0, 0, 32'h33, 32'h00000055, 0, 32'h0,        0, 32'h0,        32'h5534BEEF, 4, 1, 1, 0));
    vt.push_back(mk(1, 0, 0, 32'h30, 32'hFFFFFF66, 0, 32'h0,        0, 32'h0,        32'h5534BE66, 4, 1, 1, 0));
    vt.push_back(mk(1, 0, 0, 32'h31, 32'h00000077, 0, 32'h0,        0, 32'h0,        32'h55347766, 4, 1, 1, 0));
    vt.push_back(mk(0, 3, 0, 32'h30, 32'h0,        0, 32'h0,        1, 32'h55347766, 32'h0,        3, 1, 0, 0));
    vt.push_back(mk(0, 0, 0, 32'h30, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0,        1, 0, 0, 0));
    vt.push_back(mk(3, 1, 1, 32'h40, 32'hCAFEF00D, 0, 32'h0,        0, 32'h0,        32'hCAFEF00D, 2, 0, 1, 0));
    vt.push_back(mk(0, 3, 0, 32'h40, 32'h0,        0, 32'h0,        1, 32'hCAFEF00D, 32'h0,        3, 1, 0, 0));
`ifdef MEM_MISALIGN_TRAP_EN
    vt.push_back(mk(0, 3, 0, 32'h13, 32'h0,        1, 32'h0BADC0DE, 0, 32'h0,        32'h0,        1, 0, 0, 1));
    vt.push_back(mk(0, 2, 1, 32'h31, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0,        1, 0, 0, 1));
    vt.push_back(mk(3, 0, 0, 32'h42, 32'h01020304, 0, 32'h0,        0, 32'h0,        32'h0,        1, 0, 0, 1));
    vt.push_back(mk(0, 3, 0, 32'h40, 32'h0,        0, 32'h0,        1, 32'hCAFEF00D, 32'h0,        3, 1, 0, 0));
`else
    vt.push_back(mk(0, 3, 0, 32'h13, 32'h0,        1, 32'h0BADC0DE, 1, 32'h0BADC0DE, 32'h0,        3, 1, 0, 0));
    vt.push_back(mk(0, 2, 1, 32'h31, 32'h0,        0, 32'h0,        1, 32'h00007766, 32'h0,        3, 1, 0, 0));
    vt.push_back(mk(3, 0, 0, 32'h42, 32'h01020304, 0, 32'h0,        0, 32'h0,        32'h01020304, 2, 0, 1, 0));
    vt.push_back(mk(0, 3, 0, 32'h40, 32'h0,        0, 32'h0,        1, 32'h01020304, 32'h0,        3, 1, 0, 0));
`endif

    for (int i = 0; i < vt.size(); i++) do_access(vt[i]);

    // Reset pulsed during WAIT of a half store aborts it with no write.
    preload(6'h14, 32'hA5A5A5A5);
    bus.Req = 1'b1; bus.WriteType = 2'b10; bus.ReadType = 2'b00;
    bus.Addr = 32'h52; bus.WData = 32'h00001234;
    @(negedge CLK);
    check("abort_rd_phase", {31'b0, bus.MemRE}, 32'h1);
    @(negedge CLK);
    check("abort_wait_busy", {31'b0, bus.Busy}, 32'h1);
    RESETn = 1'b0;
    #1;
    check("abort_rdata", bus.RData, 32'h0);
    check("abort_busy", {31'b0, bus.Busy}, 32'h0);
    check("abort_done", {31'b0, bus.Done}, 32'h0);
    check("abort_memaddr", {2'b0, bus.MemAddr}, 32'h0);
    check("abort_memwdata", bus.MemWData, 32'h0);
    check("abort_memwe", {31'b0, bus.MemWE}, 32'h0);
    check("abort_memre", {31'b0, bus.MemRE}, 32'h0);
    bus.Req = 1'b0;
    last_rd = 32'h0;
    @(negedge CLK);
    RESETn = 1'b1;
    n_we_seen = 0; n_done_seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      if (bus.MemWE) n_we_seen++;
      if (bus.Done) n_done_seen++;
    end
    check("abort_no_we", n_we_seen, 0);
    check("abort_no_done", n_done_seen, 0);
    do_access(mk(0, 3, 0, 32'h50, 32'h0, 0, 32'h0, 1, 32'hA5A5A5A5, 32'h0, 3, 1, 0, 0));

    // Req held high across DONE: store then load, one idle cycle between them.
    bus.Req = 1'b1; bus.WriteType = 2'b11; bus.ReadType = 2'b00;
    bus.Addr = 32'h60; bus.WData = 32'h5EC0DA7A;
    exp_wr_q.push_back(32'h5EC0DA7A);
    exp_q.push_back(last_rd);
    d1 = 0; d2 = 0; busy_low = 0; dn = 0;
    for (int c = 1; c <= 20 && dn < 2; c++) begin
      @(negedge CLK);
      if (bus.MemWE) pop_check_wdata("b2b_wdata");
      if (dn == 1 && !bus.Busy) busy_low++;
      if (bus.Done) begin
        dn++;
        pop_check_rdata("b2b_rdata");
        if (dn == 1) begin
          d1 = c;
          bus.WriteType = 2'b00; bus.ReadType = 2'b11;
          exp_q.push_back(32'h5EC0DA7A);
          last_rd = 32'h5EC0DA7A;
        end else begin
          d2 = c;
          bus.Req = 1'b0;
        end
      end
    end
    bus.Req = 1'b0;
    if (dn < 2) $display("FAIL b2b_timeout: saw %0d of 2 Done pulses", dn);
    check("b2b_first_done", d1, 2);
    check("b2b_gap", d2 - d1, 4);
    check("b2b_busy_low", busy_low, 1);
    @(negedge CLK);
    check("b2b_idle", {31'b0, bus.Busy}, 32'h0);

    check("exp_q_drained", exp_q.size(), 0);
    check("exp_wr_q_drained", exp_wr_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
